// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode constants, instruction field positions and destination decode
package mips_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam logic [5:0] OP_RTYPE     = 6'b000000;
    localparam logic [5:0] OP_LW        = 6'b100011;
    localparam logic [2:0] OP_IMM_CLASS = 3'b001;

    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_LSB    = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
    } instr_fields_t;

    // R-type writes rd, immediate ALU ops and loads write rt, everything else writes nothing
    function automatic logic [4:0] dest_of(input logic [5:0] opcode,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        if (opcode == OP_RTYPE) begin
            return rd;
        end else if ((opcode[5:3] == OP_IMM_CLASS) || (opcode == OP_LW)) begin
            return rt;
        end
        return 5'd0;
    endfunction

endpackage

// File: rtl/opfetch_scoreboard.sv
// rtl/opfetch_scoreboard.sv - per-register busy bits for in-flight writers; OPFETCH_WB_BYPASS_EN masks same-cycle writebacks
module opfetch_scoreboard #(
    parameter int REG_DEPTH  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs_i,
    input  logic [ADDR_WIDTH-1:0] rt_i,
    input  logic [ADDR_WIDTH-1:0] dest_i,
    input  logic                  set_i,
    input  logic [ADDR_WIDTH-1:0] set_addr_i,
    input  logic                  wb_wr_i,
    input  logic [ADDR_WIDTH-1:0] wb_rw_i,
    output logic                  rs_busy_o,
    output logic                  rt_busy_o,
    output logic                  dest_busy_o
);

    logic [REG_DEPTH-1:0] busy_q;
    logic [REG_DEPTH-1:0] busy_d;

    // r0 is hard-wired, so it never reports busy even if a bit were somehow set
    function automatic logic is_busy(input logic [REG_DEPTH-1:0] vec,
                                     input logic [ADDR_WIDTH-1:0] a,
                                     input logic wr,
                                     input logic [ADDR_WIDTH-1:0] rw);
`ifdef OPFETCH_WB_BYPASS_EN
        return vec[a] && (a != '0) && !(wr && (rw == a));
`else
        logic unused_wb;
        unused_wb = wr ^ (^rw);
        return vec[a] && (a != '0);
`endif
    endfunction

    assign rs_busy_o   = is_busy(busy_q, rs_i,   wb_wr_i, wb_rw_i);
    assign rt_busy_o   = is_busy(busy_q, rt_i,   wb_wr_i, wb_rw_i);
    assign dest_busy_o = is_busy(busy_q, dest_i, wb_wr_i, wb_rw_i);

    // Writeback clears first, then an issuing writer sets, so a same-address collision stays busy
    always_comb begin
        busy_d = busy_q;
        if (wb_wr_i && (wb_rw_i != '0)) begin
            busy_d[wb_rw_i] = 1'b0;
        end
        if (set_i && (set_addr_i != '0)) begin
            busy_d[set_addr_i] = 1'b1;
        end
    end

    // Busy vector register, wiped immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - decode/operand-fetch stage with scoreboard hazards; OPFETCH_WB_BYPASS_EN enables writeback forwarding
module operand_fetch
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int RD_DEPTH   = 2,
    parameter int REG_DEPTH  = 32,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instr,
    output logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
    input  logic [DATA_WIDTH*RD_DEPTH-1:0] q,
    input  logic                           wb_wr,
    input  logic [ADDR_WIDTH-1:0]          wb_rw,
    input  logic [DATA_WIDTH-1:0]          wb_d,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_rs_val,
    output logic [DATA_WIDTH-1:0]          out_rt_val,
    output logic [DATA_WIDTH-1:0]          out_imm,
    output logic [ADDR_WIDTH-1:0]          out_dest,
    output logic [5:0]                     out_opcode,
    output logic [5:0]                     out_funct
);

    // D stage: held instruction
    logic        d_valid_q;
    logic [31:0] d_instr_q;

    // O stage: registered bundle towards execute
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_rs_val_q;
    logic [DATA_WIDTH-1:0] out_rt_val_q;
    logic [DATA_WIDTH-1:0] out_imm_q;
    logic [ADDR_WIDTH-1:0] out_dest_q;
    logic [5:0]            out_opcode_q;
    logic [5:0]            out_funct_q;

    instr_fields_t         d_f;
    logic [4:0]            d_dest;
    logic                  rs_busy;
    logic                  rt_busy;
    logic                  dest_busy;
    logic                  hazard;
    logic                  issue;
    logic [DATA_WIDTH-1:0] rs_val_d;
    logic [DATA_WIDTH-1:0] rt_val_d;
    logic                  unused_shamt;

    assign d_f.opcode = d_instr_q[OPCODE_LSB +: 6];
    assign d_f.rs     = d_instr_q[RS_LSB +: 5];
    assign d_f.rt     = d_instr_q[RT_LSB +: 5];
    assign d_f.rd     = d_instr_q[RD_LSB +: 5];
    assign d_f.funct  = d_instr_q[FUNCT_LSB +: 6];
    assign d_f.imm    = d_instr_q[IMM_LSB +: 16];
    assign unused_shamt = ^d_instr_q[10:6];

    assign d_dest = dest_of(d_f.opcode, d_f.rt, d_f.rd);

    opfetch_scoreboard #(
        .REG_DEPTH  (REG_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .rs_i        (d_f.rs),
        .rt_i        (d_f.rt),
        .dest_i      (d_dest),
        .set_i       (issue),
        .set_addr_i  (d_dest),
        .wb_wr_i     (wb_wr),
        .wb_rw_i     (wb_rw),
        .rs_busy_o   (rs_busy),
        .rt_busy_o   (rt_busy),
        .dest_busy_o (dest_busy)
    );

    assign hazard   = d_valid_q && (rs_busy || rt_busy || ((d_dest != '0) && dest_busy));
    assign issue    = d_valid_q && !hazard && (!out_valid_q || out_ready);
    assign in_ready = !d_valid_q || issue;
    assign rr       = d_valid_q ? {d_f.rt, d_f.rs} : '0;

`ifdef OPFETCH_WB_BYPASS_EN
    // Forward the writeback word when it targets a non-zero source this cycle
    always_comb begin
        rs_val_d = q[DATA_WIDTH-1:0];
        rt_val_d = q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (wb_wr && (wb_rw == d_f.rs) && (d_f.rs != '0)) begin
            rs_val_d = wb_d;
        end
        if (wb_wr && (wb_rw == d_f.rt) && (d_f.rt != '0)) begin
            rt_val_d = wb_d;
        end
    end
`else
    logic unused_wb_d;
    assign unused_wb_d = ^wb_d;
    assign rs_val_d    = q[DATA_WIDTH-1:0];
    assign rt_val_d    = q[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

    // D register: refill on accept (also in the issue cycle), otherwise drain on issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q <= 1'b0;
            d_instr_q <= '0;
        end else if (in_valid && in_ready) begin
            d_valid_q <= 1'b1;
            d_instr_q <= in_instr;
        end else if (issue) begin
            d_valid_q <= 1'b0;
        end
    end

    // O register: load on issue, hold while execute stalls, drop once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_rs_val_q <= '0;
            out_rt_val_q <= '0;
            out_imm_q    <= '0;
            out_dest_q   <= '0;
            out_opcode_q <= '0;
            out_funct_q  <= '0;
        end else if (issue) begin
            out_valid_q  <= 1'b1;
            out_rs_val_q <= rs_val_d;
            out_rt_val_q <= rt_val_d;
            out_imm_q    <= {{(DATA_WIDTH-16){d_f.imm[15]}}, d_f.imm};
            out_dest_q   <= d_dest;
            out_opcode_q <= d_f.opcode;
            out_funct_q  <= d_f.funct;
        end else if (out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_rs_val = out_rs_val_q;
    assign out_rt_val = out_rt_val_q;
    assign out_imm    = out_imm_q;
    assign out_dest   = out_dest_q;
    assign out_opcode = out_opcode_q;
    assign out_funct  = out_funct_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed and randomized checks of operand_fetch against a register-file reference model
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [9:0]  rr;
    logic [63:0] q;
    logic        wb_wr;
    logic [4:0]  wb_rw;
    logic [31:0] wb_d;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [31:0] out_imm;
    logic [4:0]  out_dest;
    logic [5:0]  out_opcode;
    logic [5:0]  out_funct;

    operand_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .rr         (rr),
        .q          (q),
        .wb_wr      (wb_wr),
        .wb_rw      (wb_rw),
        .wb_d       (wb_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rs_val (out_rs_val),
        .out_rt_val (out_rt_val),
        .out_imm    (out_imm),
        .out_dest   (out_dest),
        .out_opcode (out_opcode),
        .out_funct  (out_funct)
    );

    always #5 clk = ~clk;

    // Architectural register file: read combinationally, written by the writeback port
    logic [31:0] rf [32];
    always_comb q = {rf[rr[9:5]], rf[rr[4:0]]};

    wire [31:0] sb = dut.u_sb.busy_q;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] iq[$];
    logic [4:0]  pend[$];
    bit          auto_wb = 1'b0;
    bit          in_fire;
    bit          out_fire;
    logic [31:0] cap_rs, cap_rt, cap_imm;
    logic [4:0]  cap_dest;
    logic [5:0]  cap_opcode, cap_funct;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_dest(input logic [31:0] i);
        if (i[31:26] == 6'b000000) return i[15:11];
        if (i[31:29] == 3'b001 || i[31:26] == 6'b100011) return i[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [2:0]  op3;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        op3 = 3'($urandom);
        case ($urandom_range(0, 4))
            0:       return {6'b000000, rs, rt, rd, 5'd0, imm[5:0]};
            1:       return {3'b001, op3, rs, rt, imm};
            2:       return {6'b100011, rs, rt, imm};
            3:       return {6'b000100, rs, rt, imm};
            default: return {6'b101011, rs, rt, imm};
        endcase
    endfunction

    // Look at the DUT between edges and note which handshakes the coming edge completes
    task automatic sample();
        @(negedge clk);
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        cap_rs     = out_rs_val;
        cap_rt     = out_rt_val;
        cap_imm    = out_imm;
        cap_dest   = out_dest;
        cap_opcode = out_opcode;
        cap_funct  = out_funct;
    endtask

    // Cross the edge and bring the reference model up to date
    task automatic advance();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (out_fire) begin
            chk("bundle_expected", 32'(iq.size() != 0), 32'd1);
            if (iq.size() != 0) begin
                e = iq.pop_front();
                chk("out_rs_val", cap_rs, rf[e[25:21]]);
                chk("out_rt_val", cap_rt, rf[e[20:16]]);
                chk("out_imm", cap_imm, {{16{e[15]}}, e[15:0]});
                chk("out_dest", {27'd0, cap_dest}, {27'd0, exp_dest(e)});
                chk("out_opcode", {26'd0, cap_opcode}, {26'd0, e[31:26]});
                chk("out_funct", {26'd0, cap_funct}, {26'd0, e[5:0]});
                if (auto_wb && exp_dest(e) != 5'd0) pend.push_back(exp_dest(e));
            end
        end
        if (in_fire) iq.push_back(in_instr);
        if (wb_wr && wb_rw != 5'd0) rf[wb_rw] = wb_d;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        wb_wr = 1'b0; wb_rw = '0; wb_d = '0;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : $urandom;
        rf[9] = 32'd5; rf[10] = 32'd7;
        @(posedge clk); @(posedge clk); #1; rst = 1'b0;

        // Reset state
        sample();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_rs_val", out_rs_val, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_dest", {27'd0, out_dest}, 32'd0);
        chk("rst_rr", {22'd0, rr}, 32'd0);
        chk("rst_scoreboard", sb, 32'd0);
        advance();

        // add $8,$9,$10
        in_valid = 1'b1; in_instr = 32'h012A4020;
        sample(); chk("t1_accept", {31'd0, in_ready}, 32'd1); advance();
        in_valid = 1'b0;
        sample();
        chk("t1_lat1_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_rr", {22'd0, rr}, {22'd0, 5'd10, 5'd9});
        advance();
        sample();
        chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_rs", out_rs_val, 32'd5);
        chk("t1_rt", out_rt_val, 32'd7);
        chk("t1_dest", {27'd0, out_dest}, 32'd8);
        chk("t1_sb8", {31'd0, sb[8]}, 32'd1);
        advance();

        // add $11,$8,$8 behind the $8 writer
        in_valid = 1'b1; in_instr = 32'h01085820;
        sample(); chk("t2_accept", {31'd0, in_ready}, 32'd1); advance();
        in_valid = 1'b0; out_ready = 1'b1;
        sample(); chk("t2_stall_a", {31'd0, in_ready}, 32'd0); advance();
        sample(); chk("t2_stall_b", {31'd0, in_ready}, 32'd0);
        chk("t2_o_empty", {31'd0, out_valid}, 32'd0); advance();
        wb_wr = 1'b1; wb_rw = 5'd8; wb_d = 32'hdcaf484c;
`ifdef OPFETCH_WB_BYPASS_EN
        sample(); chk("t2_bypass_issue", {31'd0, in_ready}, 32'd1); advance();
        wb_wr = 1'b0;
`else
        sample(); chk("t2_wb_stall", {31'd0, in_ready}, 32'd0); advance();
        wb_wr = 1'b0;
        sample(); chk("t2_issue_after_wb", {31'd0, in_ready}, 32'd1);
        chk("t2_o_empty_wb", {31'd0, out_valid}, 32'd0); advance();
`endif
        sample();
        chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_rs", out_rs_val, 32'hdcaf484c);
        chk("t2_rt", out_rt_val, 32'hdcaf484c);
        advance();
        chk("t2_sb", sb, 32'h0000_0800);
        wb_wr = 1'b1; wb_rw = 5'd11; wb_d = $urandom;
        tick();
        wb_wr = 1'b0;

        // Two queued instructions behind a stalled execute stage
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00226020;
        tick();
        in_instr = 32'h00656820;
        sample(); chk("t3_accept_b", {31'd0, in_ready}, 32'd1); advance();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("t3_hold_ready", {31'd0, in_ready}, 32'd0);
            chk("t3_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t3_hold_dest", {27'd0, out_dest}, 32'd12);
            advance();
        end
        out_ready = 1'b1;
        sample(); chk("t3_first", {27'd0, out_dest}, 32'd12); advance();
        sample(); chk("t3_second_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_second", {27'd0, out_dest}, 32'd13); advance();
        sample(); chk("t3_drained", {31'd0, out_valid}, 32'd0); advance();
        wb_wr = 1'b1; wb_rw = 5'd12; wb_d = $urandom; tick();
        wb_rw = 5'd13; wb_d = $urandom; tick();
        wb_wr = 1'b0;

        // lw $4,-4($2) then beq
        in_valid = 1'b1; in_instr = 32'h8C44FFFC; tick();
        in_instr = 32'h10230010; tick();
        in_valid = 1'b0;
        sample();
        chk("t4_lw_imm", out_imm, 32'hFFFFFFFC);
        chk("t4_lw_dest", {27'd0, out_dest}, 32'd4);
        advance();
        sample();
        chk("t4_beq_dest", {27'd0, out_dest}, 32'd0);
        chk("t4_beq_opcode", {26'd0, out_opcode}, 32'd4);
        chk("t4_beq_sb", sb, 32'h0000_0010);
        advance();

        // add $4,$1,$2 issuing while r4 is being written back
        in_valid = 1'b1; in_instr = 32'h00222020; tick();
        in_valid = 1'b0; wb_wr = 1'b1; wb_rw = 5'd4; wb_d = 32'h12345678;
`ifdef OPFETCH_WB_BYPASS_EN
        sample(); chk("t5_issue_on_wb", {31'd0, in_ready}, 32'd1); advance();
        wb_wr = 1'b0;
`else
        sample(); chk("t5_waw_stall", {31'd0, in_ready}, 32'd0); advance();
        wb_wr = 1'b0;
        sample(); chk("t5_issue_after_wb", {31'd0, in_ready}, 32'd1); advance();
`endif
        sample();
        chk("t5_dest", {27'd0, out_dest}, 32'd4);
        chk("t5_sb4", sb, 32'h0000_0010);
        advance();
        tick();

        // Reset with D and O full and r4/r8 busy
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h012A4020; tick();
        in_instr = 32'h00227020; tick();
        in_valid = 1'b0;
        sample();
        chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("t6_pre_ready", {31'd0, in_ready}, 32'd0);
        chk("t6_pre_sb", sb, 32'h0000_0110);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_rst_sb", sb, 32'd0);
        chk("t6_rst_rr", {22'd0, rr}, 32'd0);
        iq.delete();
        pend.delete();
        @(posedge clk); #1; rst = 1'b0;

        // Randomized traffic; execute writes back each destination some time after taking it
        auto_wb = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !in_fire)) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_instr = gen_instr();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (pend.size() != 0 && $urandom_range(0, 1) == 1) begin
                wb_wr = 1'b1; wb_rw = pend.pop_front(); wb_d = $urandom;
            end else begin
                wb_wr = 1'b0;
            end
            tick();
            if (in_fire) in_valid = 1'b0;
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 400 && (iq.size() != 0 || pend.size() != 0); c++) begin
            if (pend.size() != 0) begin
                wb_wr = 1'b1; wb_rw = pend.pop_front(); wb_d = $urandom;
            end else begin
                wb_wr = 1'b0;
            end
            tick();
        end
        wb_wr = 1'b0;
        tick();
        chk("drain_empty", 32'(iq.size() + pend.size()), 32'd0);
        chk("drain_sb", sb, 32'd0);
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
